cache_line_fill_unit: RTL and testbench
=======================================

# cache_line_fill_unit

Memory-side stage directly downstream of the L1 cache. It takes one line-sized miss or eviction request at a time from the cache and runs it over the split request/response memory bus. For a read, it issues the line address, collects the response beats, assembles the full 64-byte line and hands it back in a single cycle. For a write-back, it issues the line address and then streams the line's beats out on the request channel. It is the only block that drives `bus_reqcyc`/`bus_respack`, so the cache never touches the bus directly.

## Interface
- `BUS_DATA_WIDTH`, 64: width of one bus beat and of the request/response data.
- `BUS_TAG_WIDTH`, 13: width of bus tags.
- `BEATS`, 8: beats per cache line (64 B line / 8 B beat).
- `MEM_READ_TAG`, 13'h1100: request and response tag for line reads.
- `MEM_WRITE_TAG`, 13'h0101: request tag for line writes.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it (0) clears all state immediately.
- `fill_valid`  in  1  cache requests a line read.
- `fill_addr`  in  64  any byte address inside the wanted line.
- `wb_valid`  in  1  cache requests a line write-back.
- `wb_addr`  in  64  any byte address inside the evicted line.
- `wb_line`  in  BEATS*64  evicted line data; beat i is bits [i*64 +: 64].
- `req_ready`  out  1  unit is IDLE and will accept `fill_valid`/`wb_valid` this cycle.
- `line_valid`  out  1  one-cycle pulse: `line_data`/`line_addr` hold a completed fill.
- `line_addr`  out  64  line-aligned address of the completed fill (low 6 bits zero).
- `line_data`  out  BEATS*64  assembled line; beat i is bits [i*64 +: 64].
- `wb_done`  out  1  one-cycle pulse when the last write beat is acknowledged.
- `bus_reqcyc`  out  1  request-channel valid.
- `bus_reqack`  in  1  memory accepts the current request-channel word.
- `bus_req`  out  64  address word or write-data beat.
- `bus_reqtag`  out  13  tag of the current request word.
- `bus_respcyc`  in  1  response beat valid.
- `bus_resp`  in  64  response beat data.
- `bus_resptag`  in  13  response tag.
- `bus_respack`  out  1  acknowledges the response beat accepted on the previous cycle.

## Operation
- **States:** IDLE, RD_REQ, RD_DATA, RD_DONE, WR_REQ, WR_DATA.
- **IDLE:** `req_ready`=1.
  - `wb_valid` has priority over `fill_valid`, so an eviction reaches memory before a refill of the same set.
  - On `wb_valid`: latch `wb_addr & ~63` and `wb_line`, then go to WR_REQ.
  - Otherwise, on `fill_valid`: latch `fill_addr & ~63`, clear the beat counter, then go to RD_REQ.
- **RD_REQ:** drive `bus_reqcyc`=1, `bus_req`=line address, `bus_reqtag`=`MEM_READ_TAG`.
  - Hold these until a cycle with `bus_reqack`=1, then drop `bus_reqcyc` and go to RD_DATA.
- **RD_DATA:** every cycle with `bus_respcyc`=1 and `bus_resptag`==`MEM_READ_TAG`:
  - store `bus_resp` into beat slot [counter];
  - increment the counter (3 bits, counts 0..BEATS-1);
  - drive `bus_respack`=1 on the next cycle.
  - On the beat taken at counter==BEATS-1, go to RD_DONE.
  - Beats with any other tag are ignored and not acked.
- **RD_DONE:** `line_valid`=1 for exactly one cycle, `line_addr`/`line_data` stable; then go to IDLE.
  - `line_data`/`line_addr` keep their value until the next fill completes.
- **WR_REQ:** same as RD_REQ but with `bus_reqtag`=`MEM_WRITE_TAG`. On ack, clear the counter and go to WR_DATA.
- **WR_DATA:** drive `bus_reqcyc`=1, `bus_req`=beat[counter], `bus_reqtag`=`MEM_WRITE_TAG`.
  - Each `bus_reqack` advances the counter.
  - On the ack of beat BEATS-1: pulse `wb_done`, drop `bus_reqcyc`, go to IDLE.
- **Stray responses:** `bus_respcyc` in any state other than RD_DATA is ignored, never acked, and never corrupts a latched line.

## Timing
- **Reset values:** state IDLE, `req_ready`=1, and every other output 0, including `line_data`, `line_addr`, `bus_req` and `bus_reqtag`.
- **Reset mid-operation:** aborts the transaction immediately. `bus_reqcyc` and `bus_respack` fall asynchronously, no `line_valid`/`wb_done` is produced, and the partial line is discarded.
- **Request issue:** if a request is accepted at edge N, `bus_reqcyc` is high from cycle N+1.
- **Read latency:** with ack on the first cycle and one beat per cycle, `line_valid` appears 1 (address) + BEATS (data) + 1 cycles after acceptance. Stalls extend this cycle-for-cycle.
- **Back-to-back requests:** `req_ready` rises the cycle after `line_valid`/`wb_done`. The minimum gap between transactions is one IDLE cycle.
- **Response ack:** `bus_respack` is a registered single-cycle pulse per accepted beat. Consecutive beats give a continuously high `bus_respack`.

## Test plan
- **Single fill:** fill_addr=0x1234_5678, immediate reqack, response beats 0x1000..0x1007 on consecutive cycles. Expect bus_req=0x1234_5640, tag 0x1100, then line_valid on cycle 10 with beat0=0x1000 and beat7=0x1007.
- **Delayed ack:** withhold bus_reqack for 5 cycles. Expect bus_req/bus_reqtag stable throughout, exactly one address word issued, and line_valid delayed by 5 cycles.
- **Write-back priority:** wb_valid and fill_valid together, wb_addr=0x80, line beats 0xA0..0xA7. Expect address 0x80 with tag 0x0101, then beats 0xA0..0xA7 each held until ack, then wb_done. req_ready returns the following cycle and the fill is then accepted.
- **Gapped/foreign beats:** two-cycle gaps between beats plus one beat tagged 0x0005. Expect the foreign beat not acked and not stored, and a correct line after 8 valid beats.
- **Reset mid-fill:** reset low after beat 3. Expect all outputs 0 asynchronously, and no line_valid after release. A new fill then completes normally with fresh data only.

Source files
------------

// File: rtl/cache_line_fill_unit_if.sv
// Split request/response memory bus between the line fill unit and memory.
// Request channel: a word transfers on any cycle where reqcyc and reqack are both high;
// the master holds reqcyc/req/reqtag stable until then. Response channel: a beat is
// offered by respcyc; the master's respack is a registered pulse one cycle after it
// takes a beat.
interface cache_line_fill_unit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13
);
  logic                  reqcyc;
  logic                  reqack;
  logic [DATA_WIDTH-1:0] req;
  logic [TAG_WIDTH-1:0]  reqtag;
  logic                  respcyc;
  logic [DATA_WIDTH-1:0] resp;
  logic [TAG_WIDTH-1:0]  resptag;
  logic                  respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/cache_line_fill_unit.sv
// Runs one line read (fill) or line write-back at a time over the split memory bus,
// assembling read beats into a full line that is presented for a single cycle.
module cache_line_fill_unit #(
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter int                       BEATS          = 8,
  parameter logic [BUS_TAG_WIDTH-1:0] MEM_READ_TAG   = 13'h1100,
  parameter logic [BUS_TAG_WIDTH-1:0] MEM_WRITE_TAG  = 13'h0101
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            fill_valid,
  input  logic [63:0]                     fill_addr,
  input  logic                            wb_valid,
  input  logic [63:0]                     wb_addr,
  input  logic [BEATS*BUS_DATA_WIDTH-1:0] wb_line,
  output logic                            req_ready,
  output logic                            line_valid,
  output logic [63:0]                     line_addr,
  output logic [BEATS*BUS_DATA_WIDTH-1:0] line_data,
  output logic                            wb_done,
  output logic [2:0]                      dbg_state,
  cache_line_fill_unit_if.master          bus
);

  localparam int          W        = BUS_DATA_WIDTH;
  localparam int          LW       = BEATS * W;
  localparam int          CW       = $clog2(BEATS);
  localparam logic [CW-1:0] LAST   = CW'(BEATS - 1);
  localparam logic [63:0] OFF_MASK = 64'(LW / 8 - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    RD_DONE = 3'd3,
    WR_REQ  = 3'd4,
    WR_DATA = 3'd5
  } state_t;

  state_t          state, state_n;
  logic [63:0]     addr_q;
  logic [LW-1:0]   buf_q;
  logic [CW-1:0]   cnt;
  logic [63:0]     line_addr_q;
  logic [LW-1:0]   line_data_q;
  logic            respack_q;
  logic            beat_take;
  logic [W-1:0]    wr_beat;

  assign beat_take = (state == RD_DATA) && bus.respcyc && (bus.resptag == MEM_READ_TAG);
  assign wr_beat   = buf_q[int'(cnt)*W +: W];

  // buf_q holds either the line being written back or the partially assembled read;
  // the visible line_data is only replaced once the final beat arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      buf_q       <= '0;
      cnt         <= '0;
      line_addr_q <= '0;
      line_data_q <= '0;
      respack_q   <= 1'b0;
    end else begin
      state     <= state_n;
      respack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_valid) begin
            addr_q <= wb_addr & ~OFF_MASK;
            buf_q  <= wb_line;
          end else if (fill_valid) begin
            addr_q <= fill_addr & ~OFF_MASK;
            cnt    <= '0;
          end
        end
        RD_DATA: begin
          if (beat_take) begin
            buf_q[int'(cnt)*W +: W] <= bus.resp;
            cnt                     <= cnt + 1'b1;
            respack_q               <= 1'b1;
            if (cnt == LAST) begin
              line_data_q <= {bus.resp, buf_q[(BEATS-1)*W-1:0]};
              line_addr_q <= addr_q;
            end
          end
        end
        WR_REQ:  if (bus.reqack) cnt <= '0;
        WR_DATA: if (bus.reqack) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    line_valid = 1'b0;
    wb_done    = 1'b0;
    bus.reqcyc = 1'b0;
    bus.req    = '0;
    bus.reqtag = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (wb_valid)        state_n = WR_REQ;
        else if (fill_valid) state_n = RD_REQ;
      end
      RD_REQ: begin
        bus.reqcyc = 1'b1;
        bus.req    = addr_q;
        bus.reqtag = MEM_READ_TAG;
        if (bus.reqack) state_n = RD_DATA;
      end
      RD_DATA: if (beat_take && cnt == LAST) state_n = RD_DONE;
      RD_DONE: begin
        line_valid = 1'b1;
        state_n    = IDLE;
      end
      WR_REQ: begin
        bus.reqcyc = 1'b1;
        bus.req    = addr_q;
        bus.reqtag = MEM_WRITE_TAG;
        if (bus.reqack) state_n = WR_DATA;
      end
      WR_DATA: begin
        bus.reqcyc = 1'b1;
        bus.req    = wr_beat;
        bus.reqtag = MEM_WRITE_TAG;
        if (bus.reqack && cnt == LAST) begin
          wb_done = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.respack = respack_q;
  assign line_addr   = line_addr_q;
  assign line_data   = line_data_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_cache_line_fill_unit.sv
// Directed bench for cache_line_fill_unit: fills, stalled ack, write-back priority,
// gapped/foreign response beats, stray responses and reset in the middle of a fill.
module tb_cache_line_fill_unit;
  localparam int LW = 512;

  logic            clk = 1'b0;
  logic            reset;
  logic            fill_valid;
  logic [63:0]     fill_addr;
  logic            wb_valid;
  logic [63:0]     wb_addr;
  logic [LW-1:0]   wb_line;
  logic            req_ready;
  logic            line_valid;
  logic [63:0]     line_addr;
  logic [LW-1:0]   line_data;
  logic            wb_done;
  logic [2:0]      dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int words    = 0;
  int t0;
  int words0;
  logic [LW-1:0] exp_line;
  logic [LW-1:0] saved_line;

  always #5 clk = ~clk;

  cache_line_fill_unit_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) bus ();

  cache_line_fill_unit dut (
    .clk        (clk),
    .reset      (reset),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_line    (wb_line),
    .req_ready  (req_ready),
    .line_valid (line_valid),
    .line_addr  (line_addr),
    .line_data  (line_data),
    .wb_done    (wb_done),
    .dbg_state  (dbg_state),
    .bus        (bus)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.reqcyc && bus.reqack) words <= words + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic [63:0] d, input logic [12:0] t, input logic exp_ack,
                      input string tag);
    bus.respcyc = 1'b1;
    bus.resp    = d;
    bus.resptag = t;
    next();
    bus.respcyc = 1'b0;
    chk(tag, bus.respack, exp_ack);
  endtask

  task automatic addr_phase(input logic [63:0] a, input logic [12:0] t, input int stall,
                            input string tag);
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_stall_cyc"}, bus.reqcyc, 1'b1);
      chk({tag, "_stall_req"}, bus.req, a);
      chk({tag, "_stall_tag"}, bus.reqtag, t);
      next();
    end
    chk({tag, "_cyc"}, bus.reqcyc, 1'b1);
    chk({tag, "_req"}, bus.req, a);
    chk({tag, "_tag"}, bus.reqtag, t);
    bus.reqack = 1'b1;
    next();
    bus.reqack = 1'b0;
  endtask

  task automatic wait_line(input int budget, input string tag);
    int k = 0;
    while (!line_valid && k < budget) begin
      next();
      k++;
    end
    chk({tag, "_line_seen"}, line_valid, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    fill_valid = 1'b0; fill_addr = '0;
    wb_valid = 1'b0;   wb_addr = '0; wb_line = '0;
    bus.reqack = 1'b0; bus.respcyc = 1'b0; bus.resp = '0; bus.resptag = '0;
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_reqcyc", bus.reqcyc, 1'b0);
    chk("rst_req", bus.req, 64'h0);
    chk("rst_reqtag", bus.reqtag, 13'h0);
    chk("rst_respack", bus.respack, 1'b0);
    chk("rst_line_valid", line_valid, 1'b0);
    chk("rst_line_addr", line_addr, 64'h0);
    chk("rst_line_data", line_data, '0);
    chk("rst_wb_done", wb_done, 1'b0);
    chk("rst_state", dbg_state, 3'd0);
    reset = 1'b1;
    next();

    // single fill, immediate ack, consecutive beats
    fill_valid = 1'b1; fill_addr = 64'h1234_5678; t0 = cyc; words0 = words;
    next();
    fill_valid = 1'b0;
    chk("t1_ready_low", req_ready, 1'b0);
    addr_phase(64'h1234_5640, 13'h1100, 0, "t1_addr");
    chk("t1_reqcyc_drop", bus.reqcyc, 1'b0);
    for (int i = 0; i < 8; i++) begin
      beat(64'h1000 + 64'(i), 13'h1100, 1'b1, "t1_ack");
      exp_line[i*64 +: 64] = 64'h1000 + 64'(i);
    end
    chk("t1_line_valid", line_valid, 1'b1);
    chk("t1_latency", LW'(cyc - t0), LW'(10));
    chk("t1_line_addr", line_addr, 64'h1234_5640);
    chk("t1_beat0", line_data[63:0], 64'h1000);
    chk("t1_beat7", line_data[511:448], 64'h1007);
    chk("t1_line_data", line_data, exp_line);
    chk("t1_words", LW'(words - words0), LW'(1));
    next();
    chk("t1_pulse_end", line_valid, 1'b0);
    chk("t1_ready_back", req_ready, 1'b1);
    chk("t1_respack_end", bus.respack, 1'b0);

    // stray response while idle
    beat(64'hBAD, 13'h1100, 1'b0, "stray_ack");
    chk("stray_line_kept", line_data, exp_line);

    // fill with reqack withheld for 5 cycles
    fill_valid = 1'b1; fill_addr = 64'h2000_0008; t0 = cyc; words0 = words;
    next();
    fill_valid = 1'b0;
    addr_phase(64'h2000_0000, 13'h1100, 5, "t2_addr");
    for (int i = 0; i < 8; i++) begin
      beat(64'h2000 + 64'(i), 13'h1100, 1'b1, "t2_ack");
      exp_line[i*64 +: 64] = 64'h2000 + 64'(i);
    end
    chk("t2_line_valid", line_valid, 1'b1);
    chk("t2_latency", LW'(cyc - t0), LW'(15));
    chk("t2_words", LW'(words - words0), LW'(1));
    chk("t2_line_addr", line_addr, 64'h2000_0000);
    chk("t2_line_data", line_data, exp_line);
    saved_line = exp_line;
    next();

    // write-back wins over a simultaneous fill
    for (int i = 0; i < 8; i++) wb_line[i*64 +: 64] = 64'hA0 + 64'(i);
    wb_valid = 1'b1; wb_addr = 64'h80;
    fill_valid = 1'b1; fill_addr = 64'h3000_0010;
    next();
    wb_valid = 1'b0;
    chk("t3_state_wr_req", dbg_state, 3'd4);
    chk("t3_ready_low", req_ready, 1'b0);
    addr_phase(64'h80, 13'h0101, 1, "t3_addr");
    for (int i = 0; i < 8; i++) begin
      chk("t3_beat_cyc", bus.reqcyc, 1'b1);
      chk("t3_beat_req", bus.req, 64'hA0 + 64'(i));
      chk("t3_beat_tag", bus.reqtag, 13'h0101);
      next();
      chk("t3_beat_hold", bus.req, 64'hA0 + 64'(i));
      bus.reqack = 1'b1;
      #1;
      chk("t3_wb_done", wb_done, (i == 7) ? 1'b1 : 1'b0);
      next();
      bus.reqack = 1'b0;
    end
    chk("t3_ready_back", req_ready, 1'b1);
    chk("t3_reqcyc_drop", bus.reqcyc, 1'b0);
    chk("t3_wb_done_pulse", wb_done, 1'b0);
    chk("t3_line_kept", line_data, saved_line);

    // pending fill now accepted: gapped beats with one foreign-tagged beat
    next();
    fill_valid = 1'b0;
    addr_phase(64'h3000_0000, 13'h1100, 0, "t4_addr");
    for (int i = 0; i < 8; i++) begin
      repeat (2) begin
        next();
        chk("t4_gap_noack", bus.respack, 1'b0);
      end
      beat(64'hB0 + 64'(i), 13'h1100, 1'b1, "t4_ack");
      exp_line[i*64 +: 64] = 64'hB0 + 64'(i);
      if (i == 3) beat(64'hDEAD, 13'h0005, 1'b0, "t4_foreign_noack");
    end
    wait_line(4, "t4");
    chk("t4_line_addr", line_addr, 64'h3000_0000);
    chk("t4_line_data", line_data, exp_line);
    next();

    // reset in the middle of a fill
    fill_valid = 1'b1; fill_addr = 64'h4000_0020;
    next();
    fill_valid = 1'b0;
    addr_phase(64'h4000_0000, 13'h1100, 0, "t5_addr");
    for (int i = 0; i < 4; i++) beat(64'hC0 + 64'(i), 13'h1100, 1'b1, "t5_ack");
    bus.respcyc = 1'b1; bus.resp = 64'hC4; bus.resptag = 13'h1100;
    reset = 1'b0;
    #1;
    chk("t5_async_respack", bus.respack, 1'b0);
    chk("t5_async_reqcyc", bus.reqcyc, 1'b0);
    chk("t5_async_req", bus.req, 64'h0);
    chk("t5_async_line_valid", line_valid, 1'b0);
    chk("t5_async_line_data", line_data, '0);
    chk("t5_async_line_addr", line_addr, 64'h0);
    chk("t5_async_ready", req_ready, 1'b1);
    chk("t5_async_state", dbg_state, 3'd0);
    bus.respcyc = 1'b0;
    next();
    next();
    reset = 1'b1;
    repeat (3) begin
      next();
      chk("t5_no_line", line_valid, 1'b0);
    end

    // fresh fill after reset
    fill_valid = 1'b1; fill_addr = 64'h5000_003F;
    next();
    fill_valid = 1'b0;
    addr_phase(64'h5000_0000, 13'h1100, 0, "t6_addr");
    for (int i = 0; i < 8; i++) begin
      beat(64'hE0 + 64'(i), 13'h1100, 1'b1, "t6_ack");
      exp_line[i*64 +: 64] = 64'hE0 + 64'(i);
    end
    wait_line(2, "t6");
    chk("t6_line_addr", line_addr, 64'h5000_0000);
    chk("t6_line_data", line_data, exp_line);
    next();
    chk("t6_ready_back", req_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
